dm_halt_ctrl: RTL and testbench
===============================

DM_HALT_CTRL -- requirements
Module: dm_halt_ctrl

Interface
REQ-001 SHALL have parameter DmBaseAddr, int unsigned, default 1: debug memory base address.
REQ-002 SHALL have parameter HaltOffset, int unsigned, default 10: halt entry offset from DmBaseAddr.
REQ-003 SHALL have parameter ExceptionOffset, int unsigned, default 12: debug exception offset from DmBaseAddr.
REQ-004 SHALL have parameter AckTimeout, int unsigned, default 15, legal 1..255: cycles to wait for core acknowledge.
REQ-005 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-007 SHALL have port haltreq_i  in  1  debugger halt request (level).
REQ-008 SHALL have port resumereq_i  in  1  debugger resume request (level).
REQ-009 SHALL have port core_halted_i  in  1  core entered debug mode (1-cycle pulse).
REQ-010 SHALL have port core_resumed_i  in  1  core left debug mode (1-cycle pulse).
REQ-011 SHALL have port core_exception_i  in  1  exception raised while in debug mode (1-cycle pulse).
REQ-012 SHALL have port redirect_ready_i  in  1  core fetch accepts redirect.
REQ-013 SHALL have port debug_req_o  out  1  debug request to core.
REQ-014 SHALL have port redirect_valid_o  out  1  fetch redirect valid.
REQ-015 SHALL have port redirect_addr_o  out  32  fetch redirect target.
REQ-016 SHALL have port halted_o  out  1  core reported halted.
REQ-017 SHALL have port resumeack_o  out  1  1-cycle pulse on completed resume.
REQ-018 SHALL have port err_o  out  1  sticky acknowledge-timeout flag.

Function
REQ-019 SHALL implement FSM states RUN, HALTING, HALT_REDIR, HALTED, EXC_REDIR, RESUMING.
REQ-020 RUN: haltreq_i=1 -> HALTING next cycle; resumereq_i ignored; haltreq_i wins on simultaneous assertion.
REQ-021 HALTING: debug_req_o=1; core_halted_i -> HALT_REDIR.
REQ-022 HALT_REDIR: redirect_valid_o=1, redirect_addr_o = DmBaseAddr+HaltOffset; hold valid and address stable until redirect_ready_i=1, then -> HALTED.
REQ-023 HALTED: halted_o=1; haltreq_i ignored; core_exception_i -> EXC_REDIR; else resumereq_i=1 -> RESUMING; exception wins if both.
REQ-024 EXC_REDIR: redirect_valid_o=1, redirect_addr_o = DmBaseAddr+ExceptionOffset; on redirect_ready_i -> HALTED; halted_o stays 1.
REQ-025 RESUMING: halted_o=1, debug_req_o=0; core_resumed_i -> RUN with resumeack_o=1 for exactly the next cycle.
REQ-026 Address sums SHALL be computed at elaboration in 32-bit unsigned, wrapping modulo 2^32.
REQ-027 redirect_addr_o SHALL be 0 when redirect_valid_o=0.
REQ-028 A redirect accepted in the same cycle valid rises (ready already high) SHALL complete in one cycle.
REQ-029 core_halted_i, core_resumed_i, core_exception_i outside the states that consume them SHALL be ignored.
REQ-030 All outputs SHALL be registered; input-to-output latency exactly 1 cycle.

Reset
REQ-031 rst_ni=0 SHALL asynchronously force state RUN, timeout counter 0, and all outputs 0, including err_o.
REQ-032 Reset mid-redirect or mid-handshake SHALL drop redirect_valid_o immediately, with no resumeack_o pulse.
REQ-033 Reset deassertion SHALL take effect on the next rising clk_i; first state after reset is RUN.

Configuration
REQ-034 Macro DM_HALT_CTRL_TIMEOUT_EN defined: 8-bit counter SHALL count cycles spent in HALTING or RESUMING and clear on entry to either.
REQ-035 With the macro defined, reaching AckTimeout cycles without acknowledge SHALL set err_o (sticky until reset); HALTING -> RUN, RESUMING -> HALTED.
REQ-036 An acknowledge arriving in the timeout cycle SHALL win over the timeout.
REQ-037 Macro not defined: no counter; FSM waits indefinitely; err_o tied 0.

Verification
REQ-038 Defaults, haltreq_i=1, core_halted_i 3 cycles later, ready=1 -> debug_req_o high for 3 cycles, redirect_addr_o=11 for 1 cycle, halted_o=1.
REQ-039 HALTED, core_exception_i pulse, ready low 4 cycles -> redirect_addr_o=13 held stable 5 cycles, then HALTED.
REQ-040 HALTED, resumereq_i=1, core_resumed_i after 2 cycles -> RUN, single resumeack_o pulse, halted_o=0.
REQ-041 Macro defined, haltreq_i=1, no core_halted_i -> err_o=1 after 15 cycles, state RUN, debug_req_o=0.
REQ-042 Reset asserted during EXC_REDIR -> redirect_valid_o=0 and halted_o=0 without a clock edge.
REQ-043 DmBaseAddr=32'hFFFFFFFF, HaltOffset=10 -> redirect_addr_o=9.

Source files
------------

// File: rtl/dm_halt_ctrl.sv
// dm_halt_ctrl: debug-mode halt/resume controller.
// Sequences a debugger halt request into a core debug request. It then
// redirects the core's fetch to the debug memory halt entry and tracks the
// halted state. A debug exception re-enters the memory at the exception
// entry. A resume is acknowledged with a single-cycle pulse.
// Optional feature: define DM_HALT_CTRL_TIMEOUT_EN to add an acknowledge
// timeout. When it fires, the FSM abandons HALTING or RESUMING and sets the
// sticky err_o flag.
module dm_halt_ctrl #(
  parameter int unsigned DmBaseAddr      = 1,
  parameter int unsigned HaltOffset      = 10,
  parameter int unsigned ExceptionOffset = 12,
  parameter int unsigned AckTimeout      = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        haltreq_i,
  input  logic        resumereq_i,
  input  logic        core_halted_i,
  input  logic        core_resumed_i,
  input  logic        core_exception_i,
  input  logic        redirect_ready_i,
  output logic        debug_req_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_addr_o,
  output logic        halted_o,
  output logic        resumeack_o,
  output logic        err_o
);

  localparam logic [2:0] RUN        = 3'd0;
  localparam logic [2:0] HALTING    = 3'd1;
  localparam logic [2:0] HALT_REDIR = 3'd2;
  localparam logic [2:0] HALTED     = 3'd3;
  localparam logic [2:0] EXC_REDIR  = 3'd4;
  localparam logic [2:0] RESUMING   = 3'd5;

  // 32-bit unsigned sums, wrapping modulo 2^32
  localparam logic [31:0] HaltAddr = 32'(DmBaseAddr + HaltOffset);
  localparam logic [31:0] ExcAddr  = 32'(DmBaseAddr + ExceptionOffset);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       timeout;

`ifdef DM_HALT_CTRL_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(AckTimeout - 1);

  logic [7:0] cnt;
  logic       waiting;
  logic       timeout_hit;

  assign waiting = (state == HALTING) || (state == RESUMING);
  assign timeout = waiting && (cnt == CntLast);
  // An acknowledge arriving in the timeout cycle takes priority over the timeout.
  assign timeout_hit = timeout &&
                       !((state == HALTING  && core_halted_i) ||
                         (state == RESUMING && core_resumed_i));

  // Count cycles spent in a wait state; any state change restarts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (waiting && (state_nxt == state)) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Sticky acknowledge-timeout flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (timeout_hit) begin
      err_o <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Next-state selection; acknowledges are checked before the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (haltreq_i) state_nxt = HALTING;
      end
      HALTING: begin
        if (core_halted_i)  state_nxt = HALT_REDIR;
        else if (timeout)   state_nxt = RUN;
      end
      HALT_REDIR: begin
        if (redirect_ready_i) state_nxt = HALTED;
      end
      HALTED: begin
        if (core_exception_i) state_nxt = EXC_REDIR;
        else if (resumereq_i) state_nxt = RESUMING;
      end
      EXC_REDIR: begin
        if (redirect_ready_i) state_nxt = HALTED;
      end
      RESUMING: begin
        if (core_resumed_i) state_nxt = RUN;
        else if (timeout)   state_nxt = HALTED;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state register and follows its inputs by exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      debug_req_o      <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_addr_o  <= '0;
      halted_o         <= 1'b0;
      resumeack_o      <= 1'b0;
    end else begin
      debug_req_o      <= (state_nxt == HALTING);
      redirect_valid_o <= (state_nxt == HALT_REDIR) || (state_nxt == EXC_REDIR);
      redirect_addr_o  <= (state_nxt == HALT_REDIR) ? HaltAddr :
                          (state_nxt == EXC_REDIR)  ? ExcAddr  : '0;
      halted_o         <= (state_nxt == HALTED) || (state_nxt == EXC_REDIR) ||
                          (state_nxt == RESUMING);
      resumeack_o      <= (state == RESUMING) && (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_dm_halt_ctrl.sv
// Directed testbench for dm_halt_ctrl. Inputs change and outputs are sampled
// on the falling clock edge. Timeout tests apply only when
// DM_HALT_CTRL_TIMEOUT_EN is defined.
module tb_dm_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        haltreq, resumereq, core_halted, core_resumed, core_exception, ready;
  logic        debug_req, valid, halted, resumeack, err;
  logic [31:0] addr;
  logic        w_debug_req, w_valid, w_halted, w_resumeack, w_err;
  logic [31:0] w_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_halt_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .haltreq_i       (haltreq),
    .resumereq_i     (resumereq),
    .core_halted_i   (core_halted),
    .core_resumed_i  (core_resumed),
    .core_exception_i(core_exception),
    .redirect_ready_i(ready),
    .debug_req_o     (debug_req),
    .redirect_valid_o(valid),
    .redirect_addr_o (addr),
    .halted_o        (halted),
    .resumeack_o     (resumeack),
    .err_o           (err)
  );

  // Base address chosen so that both entry addresses wrap past 2^32
  dm_halt_ctrl #(.DmBaseAddr(32'hFFFF_FFFF)) dut_wrap (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .haltreq_i       (haltreq),
    .resumereq_i     (resumereq),
    .core_halted_i   (core_halted),
    .core_resumed_i  (core_resumed),
    .core_exception_i(core_exception),
    .redirect_ready_i(ready),
    .debug_req_o     (w_debug_req),
    .redirect_valid_o(w_valid),
    .redirect_addr_o (w_addr),
    .halted_o        (w_halted),
    .resumeack_o     (w_resumeack),
    .err_o           (w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; haltreq = 1'b0; resumereq = 1'b0; core_halted = 1'b0;
    core_resumed = 1'b0; core_exception = 1'b0; ready = 1'b0;
    tick(); tick();
    chk("rst_debug_req", {31'd0, debug_req}, 32'd0);
    chk("rst_valid",     {31'd0, valid},     32'd0);
    chk("rst_addr",      addr,               32'd0);
    chk("rst_halted",    {31'd0, halted},    32'd0);
    chk("rst_resumeack", {31'd0, resumeack}, 32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);

    rst_n = 1'b1;
    tick();
    chk("run_idle_debug_req", {31'd0, debug_req}, 32'd0);

    // Core pulses and resumereq in RUN are ignored
    core_halted = 1'b1; core_resumed = 1'b1; core_exception = 1'b1; resumereq = 1'b1;
    tick();
    chk("run_ignore_debug_req", {31'd0, debug_req}, 32'd0);
    chk("run_ignore_halted",    {31'd0, halted},    32'd0);
    chk("run_ignore_resumeack", {31'd0, resumeack}, 32'd0);
    chk("run_ignore_valid",     {31'd0, valid},     32'd0);
    core_halted = 1'b0; core_resumed = 1'b0; core_exception = 1'b0; resumereq = 1'b0;

    // Halt: debug_req for 3 cycles, one-cycle redirect to 11, then halted
    haltreq = 1'b1; ready = 1'b1;
    tick();
    chk("halting_c1", {31'd0, debug_req}, 32'd1);
    tick();
    chk("halting_c2", {31'd0, debug_req}, 32'd1);
    tick();
    chk("halting_c3", {31'd0, debug_req}, 32'd1);
    core_halted = 1'b1; haltreq = 1'b0;
    tick();
    chk("hredir_debug_req", {31'd0, debug_req}, 32'd0);
    chk("hredir_valid",     {31'd0, valid},     32'd1);
    chk("hredir_addr",      addr,               32'd11);
    chk("hredir_wrap_addr", w_addr,             32'd9);
    core_halted = 1'b0;
    tick();
    chk("halted_valid",  {31'd0, valid},  32'd0);
    chk("halted_addr",   addr,            32'd0);
    chk("halted_halted", {31'd0, halted}, 32'd1);

    // haltreq and stray core pulses in HALTED are ignored
    haltreq = 1'b1; core_halted = 1'b1; core_resumed = 1'b1;
    tick();
    chk("halted_ignore_halted",    {31'd0, halted},    32'd1);
    chk("halted_ignore_debug_req", {31'd0, debug_req}, 32'd0);
    chk("halted_ignore_resumeack", {31'd0, resumeack}, 32'd0);
    chk("halted_ignore_valid",     {31'd0, valid},     32'd0);
    haltreq = 1'b0; core_halted = 1'b0; core_resumed = 1'b0;

    // Exception redirect with ready low for 4 cycles: address 13 held 5 cycles
    ready = 1'b0; core_exception = 1'b1;
    tick();
    core_exception = 1'b0;
    chk("eredir_wrap_addr", w_addr, 32'd11);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("eredir_valid_%0d", i),  {31'd0, valid},  32'd1);
      chk($sformatf("eredir_addr_%0d", i),   addr,            32'd13);
      chk($sformatf("eredir_halted_%0d", i), {31'd0, halted}, 32'd1);
      if (i == 4) ready = 1'b1;
      tick();
    end
    chk("eredir_done_valid",  {31'd0, valid},  32'd0);
    chk("eredir_done_addr",   addr,            32'd0);
    chk("eredir_done_halted", {31'd0, halted}, 32'd1);

    // Resume: core_resumed 2 cycles later, single resumeack pulse
    resumereq = 1'b1;
    tick();
    chk("resuming_c1_halted",    {31'd0, halted},    32'd1);
    chk("resuming_c1_debug_req", {31'd0, debug_req}, 32'd0);
    chk("resuming_c1_resumeack", {31'd0, resumeack}, 32'd0);
    resumereq = 1'b0;
    tick();
    chk("resuming_c2_halted",    {31'd0, halted},    32'd1);
    chk("resuming_c2_resumeack", {31'd0, resumeack}, 32'd0);
    core_resumed = 1'b1;
    tick();
    chk("resumeack_pulse", {31'd0, resumeack}, 32'd1);
    chk("resumed_halted",  {31'd0, halted},    32'd0);
    core_resumed = 1'b0;
    tick();
    chk("resumeack_end",     {31'd0, resumeack}, 32'd0);
    chk("run_after_resume",  {31'd0, halted},    32'd0);
    chk("run_no_debug_req",  {31'd0, debug_req}, 32'd0);

    // haltreq wins over resumereq in RUN
    haltreq = 1'b1; resumereq = 1'b1;
    tick();
    chk("prio_halt_debug_req", {31'd0, debug_req}, 32'd1);
    haltreq = 1'b0; resumereq = 1'b0; core_halted = 1'b1;
    tick();
    chk("prio_hredir_valid", {31'd0, valid}, 32'd1);
    chk("prio_hredir_addr",  addr,           32'd11);
    core_halted = 1'b0;
    tick();
    chk("prio_halted", {31'd0, halted}, 32'd1);

    // Exception wins over resumereq in HALTED; ready high completes in one cycle
    core_exception = 1'b1; resumereq = 1'b1;
    tick();
    chk("prio_exc_valid",  {31'd0, valid},  32'd1);
    chk("prio_exc_addr",   addr,            32'd13);
    chk("prio_exc_halted", {31'd0, halted}, 32'd1);
    core_exception = 1'b0; resumereq = 1'b0;
    tick();
    chk("prio_exc_done_valid",  {31'd0, valid},  32'd0);
    chk("prio_exc_done_halted", {31'd0, halted}, 32'd1);

    // Asynchronous reset during EXC_REDIR clears outputs without a clock edge
    ready = 1'b0; core_exception = 1'b1;
    tick();
    core_exception = 1'b0;
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid",     {31'd0, valid},     32'd0);
    chk("async_rst_halted",    {31'd0, halted},    32'd0);
    chk("async_rst_addr",      addr,               32'd0);
    chk("async_rst_resumeack", {31'd0, resumeack}, 32'd0);
    tick();
    rst_n = 1'b1; ready = 1'b1;
    tick();
    chk("post_rst_debug_req", {31'd0, debug_req}, 32'd0);
    chk("post_rst_halted",    {31'd0, halted},    32'd0);
    chk("post_rst_valid",     {31'd0, valid},     32'd0);

`ifdef DM_HALT_CTRL_TIMEOUT_EN
    // Acknowledge in the timeout cycle beats the timeout
    haltreq = 1'b1;
    tick();
    haltreq = 1'b0;
    repeat (14) tick();
    chk("ack_edge_debug_req", {31'd0, debug_req}, 32'd1);
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    chk("ack_edge_valid", {31'd0, valid}, 32'd1);
    chk("ack_edge_err",   {31'd0, err},   32'd0);
    tick();
    chk("ack_edge_halted", {31'd0, halted}, 32'd1);
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0; core_resumed = 1'b1;
    tick();
    core_resumed = 1'b0;
    chk("ack_edge_resumeack", {31'd0, resumeack}, 32'd1);
    tick();

    // Halt timeout: err after 15 cycles in HALTING, back to RUN
    haltreq = 1'b1;
    tick();
    repeat (14) tick();
    chk("to_halt_last_debug_req", {31'd0, debug_req}, 32'd1);
    chk("to_halt_last_err",       {31'd0, err},       32'd0);
    tick();
    chk("to_halt_err",       {31'd0, err},       32'd1);
    chk("to_halt_debug_req", {31'd0, debug_req}, 32'd0);
    haltreq = 1'b0;
    tick();
    chk("to_halt_err_sticky", {31'd0, err},       32'd1);
    chk("to_halt_run",        {31'd0, debug_req}, 32'd0);

    // Resume timeout: back to HALTED, where core_resumed is then ignored
    haltreq = 1'b1;
    tick();
    haltreq = 1'b0; core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    tick();
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0;
    repeat (15) tick();
    chk("to_res_halted", {31'd0, halted}, 32'd1);
    core_resumed = 1'b1;
    tick();
    core_resumed = 1'b0;
    chk("to_res_no_ack",  {31'd0, resumeack}, 32'd0);
    chk("to_res_halted2", {31'd0, halted},    32'd1);
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    // Without the timeout the FSM waits indefinitely in HALTING
    haltreq = 1'b1;
    repeat (20) tick();
    chk("no_to_debug_req", {31'd0, debug_req}, 32'd1);
    chk("no_to_err",       {31'd0, err},       32'd0);
    haltreq = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
